// File: rtl/arb8_rr.sv
// arb8_rr: eight-way round-robin arbiter with one-hot and encoded grant
// outputs, grant held until release with a bounded hold time.
module arb8_rr #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       e,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gidx,
  output logic       valid
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t     state, state_n;
  logic [2:0] ptr, ptr_n;
  logic [7:0] hcnt, hcnt_n;
  logic [7:0] gnt_n;
  logic [2:0] gidx_n;
  logic       valid_n;

  logic [2:0] scan_idx;
  logic [2:0] win;
  logic       found;
  logic       rel;
  logic       at_limit;

  // Rotating priority scan: first requester at or above ptr, wrapping 7 -> 0.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      scan_idx = ptr + 3'(k);
      if (!found && req[scan_idx]) begin
        found = 1'b1;
        win   = scan_idx;
      end
    end
  end

  assign at_limit = (hcnt == 8'(MAX_HOLD));
  assign rel      = done | ~req[gidx] | at_limit | e;

  // Next-state and next-output decode for the IDLE/GRANT controller.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    hcnt_n  = hcnt;
    gnt_n   = gnt;
    gidx_n  = gidx;
    valid_n = valid;
    unique case (state)
      IDLE: begin
        if (!e && found) begin
          state_n = GRANT;
          gnt_n   = 8'd1 << win;
          gidx_n  = win;
          valid_n = 1'b1;
          hcnt_n  = 8'd1;
        end else begin
          gnt_n   = '0;
          gidx_n  = '0;
          valid_n = 1'b0;
          hcnt_n  = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          state_n = IDLE;
          gnt_n   = '0;
          gidx_n  = '0;
          valid_n = 1'b0;
          hcnt_n  = '0;
          // An enable-forced withdrawal keeps the current priority position.
          if (!e) ptr_n = gidx + 3'd1;
        end else begin
          hcnt_n = hcnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, pointer, hold counter and registered grant outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      hcnt  <= '0;
      gnt   <= '0;
      gidx  <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      hcnt  <= hcnt_n;
      gnt   <= gnt_n;
      gidx  <= gidx_n;
      valid <= valid_n;
    end
  end

endmodule

// File: tb/tb_arb8_rr.sv
// Self-checking bench for arb8_rr: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural arbiter model.
module tb_arb8_rr;

  localparam int unsigned MH = 4;

  logic       clk;
  logic       rst;
  logic       e;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gidx;
  logic       valid;

  int vectors;
  int miscompares;

  // Reference model state
  bit m_valid;
  int m_idx;
  int m_ptr;
  int m_hold;

  arb8_rr #(.MAX_HOLD(MH)) dut (
    .clk  (clk),
    .rst  (rst),
    .e    (e),
    .req  (req),
    .done (done),
    .gnt  (gnt),
    .gidx (gidx),
    .valid(valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_valid = 0;
    m_idx   = 0;
    m_ptr   = 0;
    m_hold  = 0;
  endtask

  // One clock edge of the arbiter behaviour, using the inputs held across it.
  task automatic model_step(input logic [7:0] r, input logic en_n, input logic d);
    if (!m_valid) begin
      if (!en_n && r != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          int c;
          c = (m_ptr + k) % 8;
          if (r[c]) begin
            m_valid = 1;
            m_idx   = c;
            m_hold  = 1;
            break;
          end
        end
      end
    end else begin
      if (d || !r[m_idx] || m_hold == int'(MH) || en_n) begin
        m_valid = 0;
        if (!en_n) m_ptr = (m_idx + 1) % 8;
        m_hold = 0;
      end else begin
        m_hold = m_hold + 1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [7:0] eg;
    logic [2:0] ei;
    logic       ev;
    ev = m_valid;
    eg = m_valid ? (8'd1 << m_idx) : 8'h00;
    ei = m_valid ? 3'(m_idx) : 3'd0;
    vectors++;
    assert (gnt === eg) else begin
      miscompares++;
      $error("FAIL %s gnt: got %h expected %h", tag, gnt, eg);
    end
    vectors++;
    assert (gidx === ei) else begin
      miscompares++;
      $error("FAIL %s gidx: got %0d expected %0d", tag, gidx, ei);
    end
    vectors++;
    assert (valid === ev) else begin
      miscompares++;
      $error("FAIL %s valid: got %b expected %b", tag, valid, ev);
    end
  endtask

  task automatic check_const(input string tag, input logic ev, input logic [2:0] ei);
    vectors++;
    assert (valid === ev) else begin
      miscompares++;
      $error("FAIL %s valid: got %b expected %b", tag, valid, ev);
    end
    if (ev) begin
      vectors++;
      assert (gidx === ei) else begin
        miscompares++;
        $error("FAIL %s gidx: got %0d expected %0d", tag, gidx, ei);
      end
    end
  endtask

  task automatic cycle(input string tag, input logic [7:0] r, input logic en_n, input logic d);
    req  = r;
    e    = en_n;
    done = d;
    @(posedge clk);
    model_step(r, en_n, d);
    #1;
    check_model(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset(input string tag);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check_model(tag);
    check_const(tag, 1'b0, 3'd0);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst  = 1'b1;
    e    = 1'b0;
    req  = 8'h00;
    done = 1'b0;
    model_reset();
    #2;
    check_model("por");
    #1;
    rst = 1'b0;

    // Reset mid-grant of index 4, then first arbitration from ptr 0
    cycle("rst_g4", 8'h10, 1'b0, 1'b0);
    check_const("rst_g4c", 1'b1, 3'd4);
    cycle("rst_hold", 8'h10, 1'b0, 1'b0);
    pulse_reset("rst_mid");
    cycle("rst_ff", 8'hFF, 1'b0, 1'b0);
    check_const("rst_first", 1'b1, 3'd0);

    // Round robin with done pulsed each grant
    for (int i = 0; i < 8; i++) begin
      cycle("rr_rel", 8'hFF, 1'b0, 1'b1);
      check_const("rr_dead", 1'b0, 3'd0);
      cycle("rr_gnt", 8'hFF, 1'b0, 1'b0);
      check_const("rr_seq", 1'b1, 3'((i + 1) % 8));
    end
    cycle("rr_end", 8'hFF, 1'b0, 1'b1);

    // Wrap: req 81 from ptr 0 -> 0, 7, 0
    pulse_reset("rst_wrap");
    cycle("w_g0", 8'h81, 1'b0, 1'b0);
    check_const("w_0", 1'b1, 3'd0);
    cycle("w_r0", 8'h81, 1'b0, 1'b1);
    cycle("w_g7", 8'h81, 1'b0, 1'b0);
    check_const("w_7", 1'b1, 3'd7);
    cycle("w_r7", 8'h81, 1'b0, 1'b1);
    cycle("w_g0b", 8'h81, 1'b0, 1'b0);
    check_const("w_0b", 1'b1, 3'd0);
    cycle("w_r0b", 8'h81, 1'b0, 1'b1);

    // Skip: grant 5, then req 24 -> 2
    cycle("s_g5", 8'h20, 1'b0, 1'b0);
    check_const("s_5", 1'b1, 3'd5);
    cycle("s_r5", 8'h20, 1'b0, 1'b1);
    cycle("s_g2", 8'h24, 1'b0, 1'b0);
    check_const("s_2", 1'b1, 3'd2);
    cycle("s_r2", 8'h24, 1'b0, 1'b1);

    // Forced release after MH cycles, then regrant of 3
    for (int i = 0; i < int'(MH); i++) begin
      cycle("f_hold", 8'h08, 1'b0, 1'b0);
      check_const("f_high", 1'b1, 3'd3);
    end
    cycle("f_rel", 8'h08, 1'b0, 1'b0);
    check_const("f_low", 1'b0, 3'd0);
    cycle("f_regnt", 8'h08, 1'b0, 1'b0);
    check_const("f_3", 1'b1, 3'd3);
    cycle("f_done", 8'h08, 1'b0, 1'b1);

    // Enable high blocks grants
    cycle("e_blk1", 8'h02, 1'b1, 1'b0);
    check_const("e_none1", 1'b0, 3'd0);
    cycle("e_blk2", 8'h02, 1'b1, 1'b0);
    check_const("e_none2", 1'b0, 3'd0);

    // Set ptr to 6 via grant 5, grant 6, withdraw with e, regrant 6
    cycle("e_g5", 8'h20, 1'b0, 1'b0);
    cycle("e_r5", 8'h20, 1'b0, 1'b1);
    cycle("e_g6", 8'h40, 1'b0, 1'b0);
    check_const("e_6", 1'b1, 3'd6);
    cycle("e_wd", 8'h40, 1'b1, 1'b0);
    check_const("e_off", 1'b0, 3'd0);
    cycle("e_back", 8'hFF, 1'b0, 1'b0);
    check_const("e_ptr", 1'b1, 3'd6);
    cycle("e_r6", 8'hFF, 1'b0, 1'b1);

    // Requester drop on index 4, done in IDLE ignored
    cycle("d_g4", 8'h10, 1'b0, 1'b0);
    check_const("d_4", 1'b1, 3'd4);
    cycle("d_drop", 8'h00, 1'b0, 1'b0);
    check_const("d_low", 1'b0, 3'd0);
    cycle("d_idle", 8'h00, 1'b0, 1'b1);
    check_const("d_ign", 1'b0, 3'd0);
    cycle("d_next", 8'hFF, 1'b0, 1'b0);
    check_const("d_ptr5", 1'b1, 3'd5);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [7:0] r;
      logic       en_n, d;
      r    = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r = 8'h00;
      en_n = ($urandom_range(0, 9) == 0);
      d    = ($urandom_range(0, 3) == 0);
      cycle("rand", r, en_n, d);
      if ($urandom_range(0, 99) == 0) pulse_reset("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Invariant: never multi-hot, and valid matches the OR of gnt.
  always @(negedge clk) begin
    if (!rst) begin
      vectors++;
      assert ($countones(gnt) <= 1 && valid === (|gnt)) else begin
        miscompares++;
        $error("FAIL onehot gnt: got %h valid %b expected one-hot matching valid", gnt, valid);
      end
    end
  end

endmodule
